// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: turns one LOAD/STORE from the E/M register into a single 64-bit memory access.
// Latency: store 2 cycles, load 3 cycles, fault 1 cycle; each cycle of mem_gnt/mem_rvalid delay adds one.
// Backpressure: lsu_stall holds F/D/E/M until DONE; mem_req is held with stable payload until mem_gnt.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   req_valid/is_store/func3/addr/wdata   request from the E/M register (held stable while stalled)
//   lsu_stall                     pipeline freeze (combinational)
//   ld_valid, ld_data             one-cycle load writeback pulse and extended result
//   lsu_fault                     one-cycle pulse for misaligned / illegal-func3 accesses
//   mem_req/we/addr/wdata/wstrb   request side of the data-memory handshake
//   mem_gnt, mem_rvalid, mem_rdata   memory accept, read-data valid, read doubleword
module lsu_mem_stage #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_is_store,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              lsu_stall,
    output logic              ld_valid,
    output logic [63:0]       ld_data,
    output logic              lsu_fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_wstrb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [63:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t     state, state_nxt;
    logic       is_store_q;
    logic       fault_q;
    logic [2:0] func3_q;
    logic [2:0] off_q;

    // ------------------------------------------------------------------
    // Decode of the live request (only consumed in IDLE)
    // ------------------------------------------------------------------
    logic [2:0] off;
    logic       misaligned;
    logic       illegal;
    logic       req_fault;

    assign off = req_addr[2:0];

    always_comb begin
        misaligned = 1'b0;
        case (req_func3[1:0])
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = off[0];
            2'd2:    misaligned = |off[1:0];
            default: misaligned = |off;
        endcase
    end

    assign illegal   = req_is_store ? req_func3[2] : (req_func3 == 3'b111);
    assign req_fault = misaligned | illegal;

    // Store data is replicated across every lane so the strobe alone selects
    // the target bytes; no per-offset data shifter is needed.
    logic [7:0]  st_strb;
    logic [63:0] st_data;

    always_comb begin
        st_strb = 8'hFF;
        st_data = req_wdata;
        case (req_func3[1:0])
            2'd0: begin
                st_strb = 8'h01 << off;
                st_data = {8{req_wdata[7:0]}};
            end
            2'd1: begin
                st_strb = 8'h03 << off;
                st_data = {4{req_wdata[15:0]}};
            end
            2'd2: begin
                st_strb = 8'h0F << off;
                st_data = {2{req_wdata[31:0]}};
            end
            default: begin
                st_strb = 8'hFF;
                st_data = req_wdata;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load extraction from the returned doubleword
    // ------------------------------------------------------------------
    logic [63:0] ld_shift;
    logic [63:0] ld_ext;

    assign ld_shift = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        ld_ext = ld_shift;
        case (func3_q)
            3'b000:  ld_ext = {{56{ld_shift[7]}},  ld_shift[7:0]};
            3'b001:  ld_ext = {{48{ld_shift[15]}}, ld_shift[15:0]};
            3'b010:  ld_ext = {{32{ld_shift[31]}}, ld_shift[31:0]};
            3'b100:  ld_ext = {56'd0, ld_shift[7:0]};
            3'b101:  ld_ext = {48'd0, ld_shift[15:0]};
            3'b110:  ld_ext = {32'd0, ld_shift[31:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        lsu_stall = 1'b0;
        ld_valid  = 1'b0;
        lsu_fault = 1'b0;
        case (state)
            IDLE: begin
                lsu_stall = req_valid;
                if (req_valid) begin
                    state_nxt = req_fault ? DONE : REQ;
                end
            end
            REQ: begin
                lsu_stall = req_valid;
                mem_req   = 1'b1;
                if (mem_gnt) begin
                    state_nxt = is_store_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                lsu_stall = req_valid;
                if (mem_rvalid) begin
                    state_nxt = DONE;
                end
            end
            default: begin
                // Retiring cycle: the still-asserted req_valid belongs to this op.
                ld_valid  = !is_store_q && !fault_q;
                lsu_fault = fault_q;
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Captured request and memory payload
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_store_q <= 1'b0;
            fault_q    <= 1'b0;
            func3_q    <= 3'b000;
            off_q      <= 3'b000;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= 8'h00;
            ld_data    <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                is_store_q <= req_is_store;
                fault_q    <= req_fault;
                func3_q    <= req_func3;
                off_q      <= off;
                if (req_fault) begin
                    if (!req_is_store) begin
                        ld_data <= '0;
                    end
                end else begin
                    mem_we    <= req_is_store;
                    mem_addr  <= {req_addr[ADDR_W-1:3], 3'b000};
                    mem_wdata <= req_is_store ? st_data : 64'd0;
                    mem_wstrb <= req_is_store ? st_strb : 8'h00;
                end
            end
            if (state == WAIT && mem_rvalid) begin
                ld_data <= ld_ext;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_is_store;
    logic [2:0]  req_func3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        lsu_stall;
    logic        ld_valid;
    logic [63:0] ld_data;
    logic        lsu_fault;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    int tests;
    int fails;
    logic [63:0] model_ld;   // last ld_data the reference expects

    lsu_mem_stage #(.ADDR_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_is_store(req_is_store), .req_func3(req_func3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .lsu_stall(lsu_stall), .ld_valid(ld_valid), .ld_data(ld_data), .lsu_fault(lsu_fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-level reference: which bytes are written, what lands in each lane,
    // and which bytes a load gathers and how it is extended.
    function automatic void model(input logic st, input logic [2:0] f3, input logic [63:0] a,
                                  input logic [63:0] wd, input logic [63:0] rd,
                                  output logic flt, output logic [7:0] strb,
                                  output logic [63:0] wdat, output logic [63:0] ld);
        int size;
        int o;
        size = 1 << f3[1:0];
        o    = int'(a[2:0]);
        flt  = ((o % size) != 0) || (st ? (f3 >= 3'd4) : (f3 == 3'd7));
        strb = 8'h00;
        wdat = 64'd0;
        ld   = 64'd0;
        for (int i = 0; i < 8; i++) begin
            if (i >= o && i < o + size) strb[i] = 1'b1;
            wdat[8*i +: 8] = wd[8*(i % size) +: 8];
        end
        for (int j = 0; j < size; j++) begin
            if (o + j < 8) ld[8*j +: 8] = rd[8*(o+j) +: 8];
        end
        if (!f3[2] && size < 8 && ld[8*size-1]) begin
            for (int j = size; j < 8; j++) ld[8*j +: 8] = 8'hFF;
        end
    endfunction

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            req_valid  = 1'b0;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
        end
    endtask

    // Presents one op from cycle 0 and acts as the memory. Returns what was
    // observed; returns right after the first posedge following DONE so the
    // caller can chain another op back-to-back.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] wd, input logic [63:0] rd,
                          input int gnt_at, input int rv_at, input logic junk_rv,
                          output int done_cyc, output int stall_cnt, output int ldv_cnt,
                          output int flt_cnt, output int req_cnt,
                          output logic [63:0] o_addr, output logic [63:0] o_wdata,
                          output logic [7:0] o_wstrb, output logic o_we,
                          output logic o_unstable, output logic [63:0] o_ld);
        done_cyc = -1; stall_cnt = 0; ldv_cnt = 0; flt_cnt = 0; req_cnt = 0;
        o_addr = '0; o_wdata = '0; o_wstrb = '0; o_we = 1'b0; o_unstable = 1'b0; o_ld = '0;
        for (int cyc = 0; cyc < 64 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            req_valid    = 1'b1;
            req_is_store = st;
            req_func3    = f3;
            req_addr     = a;
            req_wdata    = wd;
            mem_gnt      = 1'b0;
            mem_rvalid   = 1'b0;
            mem_rdata    = {$urandom, $urandom};
            #1;
            if (mem_req) begin
                mem_gnt = (cyc >= gnt_at);
                if (junk_rv) mem_rvalid = 1'b1;
            end
            if (cyc == rv_at) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd;
            end
            #1;
            if (mem_req) begin
                if (req_cnt == 0) begin
                    o_addr = mem_addr; o_wdata = mem_wdata; o_wstrb = mem_wstrb; o_we = mem_we;
                end else if (o_addr !== mem_addr || o_wdata !== mem_wdata ||
                             o_wstrb !== mem_wstrb || o_we !== mem_we) begin
                    o_unstable = 1'b1;
                end
                req_cnt++;
            end
            if (ld_valid === 1'b1)  ldv_cnt++;
            if (lsu_fault === 1'b1) flt_cnt++;
            if (lsu_stall === 1'b1) stall_cnt++;
            else begin
                done_cyc = cyc;
                o_ld     = ld_data;
            end
        end
        @(posedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_func3 = 3'b0;
        req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({mem_req, mem_we, ld_valid, lsu_fault, lsu_stall} !== 5'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b want 00000", {mem_req, mem_we, ld_valid, lsu_fault, lsu_stall});
        end
        tests++;
        if (mem_addr !== 64'd0 || mem_wdata !== 64'd0 || mem_wstrb !== 8'h00 || ld_data !== 64'd0) begin
            fails++; $display("FAIL reset_data: addr %h wdata %h wstrb %h ld %h want all 0", mem_addr, mem_wdata, mem_wstrb, ld_data);
        end
        rst_n = 1'b1;
        model_ld = 64'd0;
        idle_cycles(1);
    endtask

    task automatic test_stores();
        int dc, sc, lv, fc, rc; logic [63:0] oa, ow, ol; logic [7:0] os; logic owe, ou;
        run_op(1'b1, 3'b011, 64'h1000, 64'h1122334455667788, 64'd0, 1, 99, 1'b0,
               dc, sc, lv, fc, rc, oa, ow, os, owe, ou, ol);
        tests++;
        if (oa !== 64'h1000 || os !== 8'hFF || ow !== 64'h1122334455667788 || owe !== 1'b1) begin
            fails++; $display("FAIL sd_payload: addr %h strb %h wdata %h we %b want 1000 ff 1122334455667788 1", oa, os, ow, owe);
        end
        tests++;
        if (dc !== 2 || sc !== 2 || rc !== 1) begin
            fails++; $display("FAIL sd_timing: done %0d stall %0d req %0d want 2 2 1", dc, sc, rc);
        end
        run_op(1'b1, 3'b000, 64'h2005, 64'hAB, 64'd0, 1, 99, 1'b0,
               dc, sc, lv, fc, rc, oa, ow, os, owe, ou, ol);
        tests++;
        if (oa !== 64'h2000 || os !== 8'h20 || ow !== 64'hABABABABABABABAB) begin
            fails++; $display("FAIL sb_payload: addr %h strb %h wdata %h want 2000 20 abababababababab", oa, os, ow);
        end
        idle_cycles(1);
    endtask

    task automatic test_loads();
        int dc, sc, lv, fc, rc; logic [63:0] oa, ow, ol; logic [7:0] os; logic owe, ou;
        run_op(1'b0, 3'b000, 64'h3003, 64'd0, 64'h0000000080000000, 1, 2, 1'b0,
               dc, sc, lv, fc, rc, oa, ow, os, owe, ou, ol);
        tests++;
        if (ol !== 64'hFFFFFFFFFFFFFF80 || dc !== 3 || lv !== 1 || os !== 8'h00 || owe !== 1'b0) begin
            fails++; $display("FAIL lb: ld %h done %0d ldv %0d strb %h we %b want ffffffffffffff80 3 1 00 0", ol, dc, lv, os, owe);
        end
        run_op(1'b0, 3'b100, 64'h3003, 64'd0, 64'h0000000080000000, 1, 2, 1'b0,
               dc, sc, lv, fc, rc, oa, ow, os, owe, ou, ol);
        tests++;
        if (ol !== 64'h80 || dc !== 3 || lv !== 1 || oa !== 64'h3000) begin
            fails++; $display("FAIL lbu: ld %h done %0d ldv %0d addr %h want 80 3 1 3000", ol, dc, lv, oa);
        end
        run_op(1'b0, 3'b110, 64'h5004, 64'd0, 64'hDEADBEEF00000000, 3, 6, 1'b1,
               dc, sc, lv, fc, rc, oa, ow, os, owe, ou, ol);
        tests++;
        if (ol !== 64'h00000000DEADBEEF || dc !== 7 || sc !== 7 || rc !== 3 || ou !== 1'b0) begin
            fails++; $display("FAIL lwu_delay: ld %h done %0d stall %0d req %0d unstable %b want deadbeef 7 7 3 0", ol, dc, sc, rc, ou);
        end
        model_ld = 64'h00000000DEADBEEF;
        idle_cycles(1);
    endtask

    task automatic test_faults();
        int dc, sc, lv, fc, rc; logic [63:0] oa, ow, ol; logic [7:0] os; logic owe, ou;
        run_op(1'b0, 3'b010, 64'h4002, 64'd0, 64'd0, 1, 2, 1'b0,
               dc, sc, lv, fc, rc, oa, ow, os, owe, ou, ol);
        tests++;
        if (dc !== 1 || sc !== 1 || rc !== 0 || lv !== 0 || fc !== 1 || ol !== 64'd0) begin
            fails++; $display("FAIL lw_misalign: done %0d stall %0d req %0d ldv %0d flt %0d ld %h want 1 1 0 0 1 0", dc, sc, rc, lv, fc, ol);
        end
        // Seed ld_data with a non-zero value so the clear on a faulted load is visible.
        run_op(1'b0, 3'b011, 64'h4000, 64'd0, 64'h5555AAAA5555AAAA, 1, 2, 1'b0,
               dc, sc, lv, fc, rc, oa, ow, os, owe, ou, ol);
        run_op(1'b0, 3'b111, 64'h4000, 64'd0, 64'd0, 1, 2, 1'b0,
               dc, sc, lv, fc, rc, oa, ow, os, owe, ou, ol);
        tests++;
        if (dc !== 1 || rc !== 0 || lv !== 0 || fc !== 1 || ol !== 64'd0) begin
            fails++; $display("FAIL ld_f3_111: done %0d req %0d ldv %0d flt %0d ld %h want 1 0 0 1 0", dc, rc, lv, fc, ol);
        end
        model_ld = 64'd0;
        idle_cycles(1);
    endtask

    task automatic test_reset_in_wait();
        int dc, sc, lv, fc, rc; logic [63:0] oa, ow, ol; logic [7:0] os; logic owe, ou;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; req_func3 = 3'b011; req_addr = 64'h6000;
        @(negedge clk);
        #1;
        tests++;
        if (mem_req !== 1'b1) begin
            fails++; $display("FAIL rst_wait_req: mem_req %b want 1", mem_req);
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        rst_n = 1'b0; req_valid = 1'b0;
        #1;
        tests++;
        if ({mem_req, lsu_stall, ld_valid, lsu_fault, mem_we} !== 5'b0 ||
            mem_addr !== 64'd0 || mem_wstrb !== 8'h00 || ld_data !== 64'd0) begin
            fails++; $display("FAIL rst_wait_clear: ctrl %b addr %h strb %h ld %h want 0", {mem_req, lsu_stall, ld_valid, lsu_fault, mem_we}, mem_addr, mem_wstrb, ld_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 64'hBADBADBADBADBAD0;
        #1;
        tests++;
        if (ld_valid !== 1'b0 || lsu_stall !== 1'b0) begin
            fails++; $display("FAIL stale_rvalid: ldv %b stall %b want 0 0", ld_valid, lsu_stall);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        run_op(1'b0, 3'b011, 64'h6008, 64'd0, 64'h0123456789ABCDEF, 1, 2, 1'b0,
               dc, sc, lv, fc, rc, oa, ow, os, owe, ou, ol);
        tests++;
        if (ol !== 64'h0123456789ABCDEF || dc !== 3 || lv !== 1 || oa !== 64'h6008) begin
            fails++; $display("FAIL ld_after_rst: ld %h done %0d ldv %0d addr %h want 0123456789abcdef 3 1 6008", ol, dc, lv, oa);
        end
        model_ld = 64'h0123456789ABCDEF;
        idle_cycles(1);
    endtask

    task automatic test_random();
        int dc, sc, lv, fc, rc; logic [63:0] oa, ow, ol; logic [7:0] os; logic owe, ou;
        logic st, junk, e_flt; logic [2:0] f3; logic [63:0] a, wd, rd, m, e_wd, e_ld;
        logic [7:0] e_strb; int g, r, e_done;
        for (int n = 0; n < 200; n++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) begin
                m = (64'd1 << f3[1:0]) - 64'd1;
                a = a & ~m;
            end
            wd   = {$urandom, $urandom};
            rd   = {$urandom, $urandom};
            g    = $urandom_range(1, 4);
            r    = g + 1 + $urandom_range(0, 3);
            junk = 1'($urandom_range(0, 1));
            model(st, f3, a, wd, rd, e_flt, e_strb, e_wd, e_ld);
            e_done = e_flt ? 1 : (st ? g + 1 : r + 1);
            if (!st) model_ld = e_flt ? 64'd0 : e_ld;
            run_op(st, f3, a, wd, rd, g, r, junk, dc, sc, lv, fc, rc, oa, ow, os, owe, ou, ol);
            tests++;
            if (dc !== e_done || sc !== e_done || rc !== (e_flt ? 0 : g) ||
                lv !== ((!st && !e_flt) ? 1 : 0) || fc !== (e_flt ? 1 : 0) || ou !== 1'b0) begin
                fails++; $display("FAIL rnd_timing[%0d]: st %b f3 %0d a %h done %0d stall %0d req %0d ldv %0d flt %0d unst %b want done %0d req %0d flt %b",
                                  n, st, f3, a, dc, sc, rc, lv, fc, ou, e_done, e_flt ? 0 : g, e_flt);
            end
            if (!e_flt) begin
                tests++;
                if (oa !== {a[63:3], 3'b000} || owe !== st || os !== (st ? e_strb : 8'h00) ||
                    (st && ow !== e_wd)) begin
                    fails++; $display("FAIL rnd_payload[%0d]: addr %h we %b strb %h wdata %h want addr %h we %b strb %h wdata %h",
                                      n, oa, owe, os, ow, {a[63:3], 3'b000}, st, st ? e_strb : 8'h00, e_wd);
                end
            end
            tests++;
            if (ol !== model_ld) begin
                fails++; $display("FAIL rnd_ld[%0d]: st %b f3 %0d a %h ld %h want %h", n, st, f3, a, ol, model_ld);
            end
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_ld = 64'd0;
        test_reset();
        test_stores();
        test_loads();
        test_faults();
        test_reset_in_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
